// File: rtl/mem_arbiter_rr_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_arbiter_rr_if                                           |
// | Brief  : Cache-channel and RAM-port bundle of the round-robin memory |
// |          arbiter. slave = arbiter view, master = caches + RAM view.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface mem_arbiter_rr_if #(
    parameter int NCH    = 2,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    // cache-side channels
    logic [NCH-1:0]        ch_ren;
    logic [NCH-1:0]        ch_wen;
    logic [NCH-1:0]        ch_lock;
    logic [NCH*ADDR_W-1:0] ch_addr;
    logic [NCH*WORD_W-1:0] ch_store;
    logic [NCH-1:0]        ch_wait;
    logic [WORD_W-1:0]     ch_load;
    logic [NCH-1:0]        ch_err;

    // RAM port
    logic                  ramREN;
    logic                  ramWEN;
    logic [ADDR_W-1:0]     ramaddr;
    logic [WORD_W-1:0]     ramstore;
    logic [WORD_W-1:0]     ramload;
    logic [1:0]            ramstate;

    // status
    logic                  busy;
    logic [GW-1:0]         grant_id;

    modport slave (
        input  ch_ren, ch_wen, ch_lock, ch_addr, ch_store,
        output ch_wait, ch_load, ch_err,
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate,
        output busy, grant_id
    );

    modport master (
        output ch_ren, ch_wen, ch_lock, ch_addr, ch_store,
        input  ch_wait, ch_load, ch_err,
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate,
        input  busy, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_arbiter_rr                                              |
// | Brief  : N-channel round-robin arbiter in front of a single RAM port |
// |          using the FREE/BUSY/ACCESS/ERROR ramstate handshake, with   |
// |          optional locked bursts of up to MAX_LOCK beats.             |
// |          Optional macro MEM_ARB_TIMEOUT_EN adds a BUSY watchdog and  |
// |          the sticky timeout_o output.                                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mem_arbiter_rr #(
    parameter int NCH      = 2,
    parameter int WORD_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_rr_if.slave bus
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic            timeout_o
`endif
);
    localparam int c_GW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int c_GW1 = c_GW + 1;
    localparam int c_LW  = $clog2(MAX_LOCK + 1);

    localparam logic [c_GW:0]   c_NCH_W     = c_GW1'(NCH);
    localparam logic [c_GW:0]   c_ONE_W     = c_GW1'(1);
    localparam logic [c_LW-1:0] c_LOCK_LAST = c_LW'(MAX_LOCK - 1);
    localparam logic [c_LW-1:0] c_LOCK_ONE  = c_LW'(1);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_XFER = 1'b1;

    localparam logic [1:0] c_RS_ACCESS = 2'd2;
    localparam logic [1:0] c_RS_ERROR  = 2'd3;

    logic [0:0]        r_state,    w_state_nxt;
    logic [c_GW-1:0]   r_grant,    w_grant_nxt;
    logic [c_GW-1:0]   r_rr_ptr,   w_rr_nxt;
    logic [c_LW-1:0]   r_lock_cnt, w_lock_nxt;

    logic [NCH-1:0]    w_req;
    logic [ADDR_W-1:0] w_addr_a  [NCH];
    logic [WORD_W-1:0] w_store_a [NCH];

    logic              w_xfer;
    logic              w_g_req;
    logic              w_g_ren;
    logic              w_g_wen;
    logic              w_g_lock;
    logic              w_rsp_hit;
    logic              w_to_hit;
    logic              w_done;
    logic              w_err_pulse;

    logic              w_found;
    logic [c_GW-1:0]   w_pick;
    logic [c_GW:0]     w_idx;
    logic [c_GW:0]     w_inc;
    logic [c_GW-1:0]   w_g_inc;

    // Unpack flat per-channel buses and form per-channel request flags
    always_comb begin
        w_req = bus.ch_ren | bus.ch_wen;
        for (int i = 0; i < NCH; i++) begin
            w_addr_a[i]  = bus.ch_addr[i*ADDR_W +: ADDR_W];
            w_store_a[i] = bus.ch_store[i*WORD_W +: WORD_W];
        end
    end

    assign w_xfer      = (r_state == c_S_XFER);
    assign w_g_req     = w_req[r_grant];
    assign w_g_ren     = bus.ch_ren[r_grant];
    assign w_g_wen     = bus.ch_wen[r_grant];
    assign w_g_lock    = bus.ch_lock[r_grant];
    assign w_rsp_hit   = (bus.ramstate == c_RS_ACCESS) || (bus.ramstate == c_RS_ERROR);
    // A withdrawn request never completes, even if the RAM answers that cycle.
    assign w_done      = w_xfer && w_g_req && (w_rsp_hit || w_to_hit);
    assign w_err_pulse = w_to_hit || (w_done && (bus.ramstate == c_RS_ERROR));

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 256;
    localparam int          c_TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout;

    // The TIMEOUT-th consecutive waiting cycle force-completes the beat.
    assign w_to_hit  = w_xfer && w_g_req && !w_rsp_hit && (r_to_cnt == c_TO_LAST);
    assign timeout_o = r_timeout;

    // Watchdog counter of waiting XFER cycles and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
            if (w_xfer && w_g_req && !w_rsp_hit && !w_to_hit) begin
                r_to_cnt <= r_to_cnt + c_TO_ONE;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    // Rotating-priority search starting at r_rr_ptr, plus grant+1 mod NCH
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        w_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = {1'b0, r_rr_ptr} + c_GW1'(k);
            if (w_idx >= c_NCH_W) begin
                w_idx = w_idx - c_NCH_W;
            end
            if (!w_found && w_req[w_idx[c_GW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[c_GW-1:0];
            end
        end
        w_inc = {1'b0, r_grant} + c_ONE_W;
        if (w_inc >= c_NCH_W) begin
            w_inc = '0;
        end
        w_g_inc = w_inc[c_GW-1:0];
    end

    // Next-state logic: grant selection, burst continuation, release
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_lock_nxt  = r_lock_cnt;
        case (r_state)
            c_S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_S_XFER;
                    w_grant_nxt = w_pick;
                    w_lock_nxt  = '0;
                end
            end
            c_S_XFER: begin
                if (!w_g_req) begin
                    // Withdrawal: give up the slot without moving priority.
                    w_state_nxt = c_S_IDLE;
                end else if (w_done) begin
                    if (w_g_lock && !w_to_hit && (r_lock_cnt < c_LOCK_LAST)) begin
                        w_lock_nxt = r_lock_cnt + c_LOCK_ONE;
                    end else begin
                        w_state_nxt = c_S_IDLE;
                        w_rr_nxt    = w_g_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Grant FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_lock_cnt <= w_lock_nxt;
        end
    end

    // RAM port mux and per-channel completion signalling
    always_comb begin
        bus.ch_wait  = '1;
        bus.ch_err   = '0;
        bus.ch_load  = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        if (w_xfer) begin
            bus.ramREN   = w_g_ren && !w_g_wen;
            bus.ramWEN   = w_g_wen;
            bus.ramaddr  = w_addr_a[r_grant];
            bus.ramstore = w_store_a[r_grant];
            if (w_done) begin
                bus.ch_wait[r_grant] = 1'b0;
                bus.ch_err[r_grant]  = w_err_pulse;
                bus.ch_load          = w_to_hit ? '0 : bus.ramload;
            end
        end
        bus.busy     = w_xfer;
        bus.grant_id = r_grant;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_mem_arbiter_rr                                           |
// | Brief  : Scoreboard bench for mem_arbiter_rr with a latency-         |
// |          programmable RAM model (4 channels, MAX_LOCK=4).            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_mem_arbiter_rr;
    localparam int NCH      = 4;
    localparam int WORD_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int MAX_LOCK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_rr_if #(.NCH(NCH), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();
`ifdef MEM_ARB_TIMEOUT_EN
    logic timeout_o;
`endif

    mem_arbiter_rr #(
        .NCH(NCH), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .timeout_o(timeout_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic        err;
        logic        wr;
        int          gap;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   comp_cnt = 0;
    int   cyc      = 0;
    int   last_cyc = 0;
    int   ren_cyc  = 0;

    // RAM model: answers ACCESS (or ERROR) after lat BUSY cycles
    logic [31:0] mem [64];
    int          lat     = 0;
    logic        rsp_err = 1'b0;
    int          rcnt    = 0;
    logic        ram_en;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        logic [5:0] idx;
        idx = a[7:2];
        return 32'hA500_0000 + {26'd0, idx};
    endfunction

    function automatic void push(input int ch, input logic [31:0] d, input logic err,
                                 input logic wr, input int gap);
        exp_t e;
        e.ch = ch; e.data = d; e.err = err; e.wr = wr; e.gap = gap;
        sbq.push_back(e);
    endfunction

    always_comb begin
        ram_en = bus.ramREN | bus.ramWEN;
        if (!ram_en)          bus.ramstate = 2'd0;
        else if (rcnt >= lat) bus.ramstate = rsp_err ? 2'd3 : 2'd2;
        else                  bus.ramstate = 2'd1;
        bus.ramload = mem[bus.ramaddr[7:2]];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!ram_en || bus.ramstate[1]) rcnt <= 0;
        else                            rcnt <= rcnt + 1;
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 + 32'(i);
            mem[16] <= 32'hDEAD_BEEF;
        end else if (bus.ramWEN && bus.ramstate == 2'd2) begin
            mem[bus.ramaddr[7:2]] <= bus.ramstore;
        end
    end

    // Monitor: pops the scoreboard on every completion
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.ramREN) ren_cyc++;
                if (&bus.ch_wait) begin
                    chk_eq("idle_load", bus.ch_load, 0);
                    chk_eq("idle_err", bus.ch_err, 0);
                end else begin
                    chk_eq("one_done", $countones(~bus.ch_wait), 1);
                    for (int i = 0; i < NCH; i++) begin
                        if (!bus.ch_wait[i]) begin
                            if (sbq.size() == 0) begin
                                chk_eq("spurious_chan", i, NCH);
                            end else begin
                                e = sbq.pop_front();
                                chk_eq("chan", i, e.ch);
                                if (!e.wr) chk_eq("load", bus.ch_load, e.data);
                                chk_eq("err", bus.ch_err, e.err ? (64'd1 << e.ch) : 64'd0);
                                if (e.gap > 0) chk_eq("gap", cyc - last_cyc, e.gap);
                                last_cyc = cyc;
                                comp_cnt++;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_comp(input int target, input int budget);
        int n = 0;
        while (comp_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (comp_cnt < target) chk_eq("wait_budget", comp_cnt, target);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk_eq("rst_busy", bus.busy, 0);
        chk_eq("rst_grant", bus.grant_id, 0);
        chk_eq("rst_wait", bus.ch_wait, 4'hF);
        chk_eq("rst_err", bus.ch_err, 0);
        chk_eq("rst_load", bus.ch_load, 0);
        chk_eq("rst_ren", bus.ramREN, 0);
        chk_eq("rst_wen", bus.ramWEN, 0);
        chk_eq("rst_addr", bus.ramaddr, 0);
        chk_eq("rst_store", bus.ramstore, 0);
    endtask

    task automatic set_addr(input int ch, input logic [31:0] a);
        bus.ch_addr[ch*ADDR_W +: ADDR_W] = a;
    endtask

    initial begin
        int base;
        bus.ch_ren   = '0;
        bus.ch_wen   = '0;
        bus.ch_lock  = '0;
        bus.ch_addr  = '0;
        bus.ch_store = '0;
        for (int i = 0; i < NCH; i++) set_addr(i, 32'h20 + 32'(i * 8));

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        tick();
        rst = 1'b0;

        // single read, three BUSY cycles then ACCESS
        lat = 3; ren_cyc = 0;
        set_addr(0, 32'h40);
        bus.ch_ren = 4'b0001;
        push(0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
        base = comp_cnt;
        wait_comp(base + 1, 20);
        bus.ch_ren = '0;
        @(negedge clk);
        chk_eq("single_ren_cycles", ren_cyc, 4);
        chk_eq("single_busy_after", bus.busy, 0);
        set_addr(0, 32'h20);
        tick();

        // fairness: all channels, ACCESS every cycle; rr_ptr starts at 1
        lat = 0;
        bus.ch_ren = 4'hF;
        for (int k = 0; k < 7; k++) begin
            int c;
            c = (1 + k) % NCH;
            push(c, init_word(32'h20 + 32'(c * 8)), 1'b0, 1'b0, (k == 0) ? 0 : 2);
        end
        base = comp_cnt;
        wait_comp(base + 7, 40);
        bus.ch_ren = '0;
        tick();

        // locked burst on ch0 with ch1 competing; rr_ptr is 0
        bus.ch_lock = 4'b0001;
        bus.ch_ren  = 4'b0011;
        push(0, init_word(32'h20), 1'b0, 1'b0, 0);
        for (int k = 0; k < 3; k++) push(0, init_word(32'h20), 1'b0, 1'b0, 1);
        push(1, init_word(32'h28), 1'b0, 1'b0, 2);
        base = comp_cnt;
        wait_comp(base + 5, 30);
        bus.ch_ren  = '0;
        bus.ch_lock = '0;
        tick();

        // read+write on ch1 is a write; then read it back
        lat = 1;
        set_addr(1, 32'h80);
        bus.ch_store[1*WORD_W +: WORD_W] = 32'h0000_1234;
        bus.ch_ren = 4'b0010;
        bus.ch_wen = 4'b0010;
        push(1, 32'h0, 1'b0, 1'b1, 0);
        base = comp_cnt;
        tick();
        @(negedge clk);
        chk_eq("rw_wen", bus.ramWEN, 1);
        chk_eq("rw_ren", bus.ramREN, 0);
        chk_eq("rw_store", bus.ramstore, 32'h1234);
        chk_eq("rw_addr", bus.ramaddr, 32'h80);
        chk_eq("rw_grant", bus.grant_id, 1);
        wait_comp(base + 1, 20);
        bus.ch_ren = '0;
        bus.ch_wen = '0;
        tick();
        bus.ch_ren = 4'b0010;
        push(1, 32'h0000_1234, 1'b0, 1'b0, 0);
        base = comp_cnt;
        wait_comp(base + 1, 20);
        bus.ch_ren = '0;
        set_addr(1, 32'h28);
        tick();

        // ERROR response on ch2
        lat = 0; rsp_err = 1'b1;
        bus.ch_ren = 4'b0100;
        push(2, init_word(32'h30), 1'b1, 1'b0, 0);
        base = comp_cnt;
        wait_comp(base + 1, 20);
        bus.ch_ren = '0;
        rsp_err = 1'b0;
        tick();

        // withdrawal of ch3 mid-BUSY; rr_ptr must stay 3
        lat = 100;
        bus.ch_ren = 4'b1000;
        tick();
        tick();
        bus.ch_ren = '0;
        @(negedge clk);
        chk_eq("wd_ren_drop", bus.ramREN, 0);
        tick();
        @(negedge clk);
        chk_eq("wd_busy", bus.busy, 0);
        tick();
        lat = 0;
        bus.ch_ren = 4'b1010;
        push(3, init_word(32'h38), 1'b0, 1'b0, 0);
        push(1, init_word(32'h28), 1'b0, 1'b0, 2);
        base = comp_cnt;
        wait_comp(base + 2, 20);
        bus.ch_ren = '0;
        tick();

        // reset during BUSY on ch2 (rr_ptr was 2)
        lat = 100;
        bus.ch_ren = 4'b0100;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.ch_ren = '0;
        @(negedge clk);
        check_reset_outputs();
        tick();
        lat = 0;
        bus.ch_ren = 4'b1001;
        push(0, init_word(32'h20), 1'b0, 1'b0, 0);
        push(3, init_word(32'h38), 1'b0, 1'b0, 2);
        base = comp_cnt;
        wait_comp(base + 2, 20);
        bus.ch_ren = '0;
        repeat (3) tick();

        chk_eq("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- N-channel round-robin arbiter between cache-side requesters (I-caches, D-caches, tensor load/store units) and the single RAM port.
- Generalises the fixed icache/dcache controller in three ways: any channel count, fair rotating priority, and optional locked multi-beat bursts.
- Registered grant FSM sits between the cache interfaces and the RAM model.
- Uses the RAM's ramstate handshake: FREE/BUSY/ACCESS/ERROR.

Parameters:
- NCH, 2, number of requesting channels (>=2).
- WORD_W, 32, data word width.
- ADDR_W, 32, address width.
- MAX_LOCK, 8, max consecutive beats a locked channel may hold the grant (>=1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ch_ren  in  NCH  per-channel read request
- ch_wen  in  NCH  per-channel write request
- ch_lock  in  NCH  keep grant after the current beat (burst)
- ch_addr  in  NCH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W]
- ch_store  in  NCH*WORD_W  per-channel write data
- ch_wait  out  NCH  1 = request not yet complete
- ch_load  out  WORD_W  read data, broadcast to all channels
- ch_err  out  NCH  one-cycle pulse: RAM returned ERROR for this channel's beat
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  RAM state: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- busy  out  1  FSM is in XFER
- grant_id  out  clog2(NCH)  currently granted channel

Behaviour:
- Reset values (rst sampled high at a clock edge):
  - state=IDLE; rr_ptr=0; grant_id=0; lock_cnt=0; busy=0.
  - ch_wait all 1; ch_err all 0; ch_load=0; ramREN/ramWEN=0; ramaddr/ramstore=0.
- Requests: channel i requests when ch_ren[i] | ch_wen[i]. If both are set, the beat is a write.
- Channel rules: hold addr, store and enables stable while ch_wait[i]=1.
- IDLE:
  - Pick the first requester scanning i = rr_ptr, rr_ptr+1, ... modulo NCH.
  - Register it into grant_id; go to XFER; lock_cnt=0.
  - No requester: stay in IDLE. All ram enables are 0 in IDLE.
- XFER:
  - ramREN/ramWEN/ramaddr/ramstore are driven combinationally from the granted channel's inputs.
  - Only the granted channel can see ch_wait=0.
  - ramstate FREE/BUSY: hold.
  - ramstate ACCESS: ch_wait[g]=0 and ch_load=ramload in the same cycle; the beat is complete.
  - ramstate ERROR: same completion as ACCESS, plus ch_err[g]=1 for that cycle.
- On completion:
  - If ch_lock[g]=1 and lock_cnt < MAX_LOCK-1: stay in XFER; lock_cnt++; rr_ptr unchanged.
  - Otherwise: go to IDLE; rr_ptr=(g+1) mod NCH.
- Latency: request in IDLE at cycle 0 -> ram enables asserted cycle 1 -> earliest completion cycle 1. Minimum 2 cycles per unlocked beat. Locked back-to-back beats need no IDLE bubble.
- Withdrawal: if the granted channel drops both ren and wen in XFER, go to IDLE next cycle; rr_ptr unchanged; no error.
- Simultaneous requests: rotation guarantees no channel waits more than (NCH-1) grants of MAX_LOCK beats each.
- Wrap-around: rr_ptr wraps from NCH-1 to 0.
- Reset mid-XFER: the beat is abandoned; ram enables drop the same cycle the reset edge takes effect.
- ch_load when no completion: holds 0.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN, with localparam TIMEOUT=256.
- Defined: a counter increments each XFER cycle where ramstate is BUSY or FREE and clears on completion. When it reaches TIMEOUT:
  - the beat is force-completed: ch_wait[g]=0, ch_err[g]=1, ch_load=0;
  - the FSM returns to IDLE and rr_ptr advances;
  - sticky output timeout_o=1 (cleared only by rst).
- Undefined: no counter and no timeout_o port; the arbiter waits on BUSY indefinitely.

Test Plan:
- Single channel: NCH=2, ch_ren[0], addr 0x40, ramstate BUSY for 3 cycles then ACCESS with ramload 0xDEADBEEF -> ch_wait[0]=0 for exactly one cycle with ch_load=0xDEADBEEF; ramREN high cycles 1-4; ch_wait[1] stays 1.
- Fairness: NCH=4, all channels request continuously, ACCESS every cycle -> grant sequence 0,1,2,3,0,1,... with one IDLE cycle between beats.
- Read+write on one channel: ch_ren[1]=ch_wen[1]=1, store 0x1234 -> ramWEN=1, ramREN=0, ramstore=0x1234.
- Lock: ch_lock[0]=1 with MAX_LOCK=4, channel 1 also requesting -> exactly 4 consecutive channel-0 beats, then grant_id=1.
- Error and withdrawal: ramstate ERROR -> ch_err[g] one-cycle pulse with ch_wait low. Separately, drop ch_ren mid-BUSY -> IDLE next cycle, rr_ptr unchanged.
- Reset mid-XFER: assert rst during BUSY -> next cycle all outputs at reset values; a following request is granted starting from channel 0.
